// File: rtl/tpu_pkg.sv
// Shared definitions for the matrix-unit result path.
// Holds the result streamer FSM encoding and the C element indices, which
// the controller uses too, so both ends agree on how output_sel numbers
// the 2x2 result tile.
package tpu_pkg;

    // Streamer FSM: wait for a done pulse, copy the tile, then emit it.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_STREAM  = 2'd2
    } stream_state_e;

    // C element indices as driven on output_sel and used as beat pointer.
    localparam logic [1:0] C00 = 2'd0;
    localparam logic [1:0] C01 = 2'd1;
    localparam logic [1:0] C10 = 2'd2;
    localparam logic [1:0] C11 = 2'd3;

    localparam int ELEMS = 4;

    // True for the final element of a tile (the beat that carries m_last).
    function automatic logic is_last_elem(input logic [1:0] idx);
        return (idx == C11);
    endfunction

endpackage

// File: rtl/result_streamer.sv
// result_streamer
// Copies the 2x2 C tile out of the matrix-unit controller after each done
// pulse and replays it as a four-beat valid/ready stream (C00..C11).
//
// Ports
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   mmu_done      one-cycle done pulse from the controller
//   c_data        controller out_data, combinational from output_en/output_sel
//   output_en     read enable to the controller (CAPTURE only)
//   output_sel    element index to the controller (0=C00 .. 3=C11)
//   m_valid       stream beat valid
//   m_ready       downstream accept
//   m_data        stream beat payload
//   m_last        marks the C11 beat
//   overflow      sticky: a done pulse arrived while busy and was dropped
//   clr_overflow  synchronous clear of overflow (a same-cycle set wins)
//   result_count  number of fully streamed tiles, wraps 255 -> 0
//   dbg_state_o   current FSM state, for observation only
//
// Stream handshake: a beat transfers on a rising edge where m_valid and
// m_ready are both high. Once m_valid rises it stays high, and m_data and
// m_last stay unchanged, until that transfer happens; m_ready is ignored
// whenever m_valid is low.
module result_streamer
    import tpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mmu_done,
    input  logic [DATA_W-1:0] c_data,
    output logic              output_en,
    output logic [1:0]        output_sel,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic [7:0]        result_count,
    output stream_state_e     dbg_state_o
);

    stream_state_e     state_q, state_d;
    logic [1:0]        idx_q, idx_d;      // capture index
    logic [1:0]        ptr_q, ptr_d;      // beat pointer
    logic [DATA_W-1:0] buf_q [ELEMS];
    logic [DATA_W-1:0] buf_d [ELEMS];
    logic              overflow_q, overflow_d;
    logic [7:0]        count_q, count_d;

    logic              accept;
    logic              last_accept;
    logic              ovf_set;

    assign accept      = (state_q == ST_STREAM) && m_ready;
    assign last_accept = accept && is_last_elem(ptr_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_set = 1'b0;
        for (int i = 0; i < ELEMS; i++) begin
            buf_d[i] = buf_q[i];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (mmu_done) begin
                    state_d = ST_CAPTURE;
                    idx_d   = C00;
                end
            end

            ST_CAPTURE: begin
                // The controller holds C steady long enough that a plain
                // one-element-per-cycle copy needs no handshake.
                buf_d[idx_q] = c_data;
                if (mmu_done) begin
                    ovf_set = 1'b1;
                end
                if (is_last_elem(idx_q)) begin
                    state_d = ST_STREAM;
                    idx_d   = C00;
                    ptr_d   = C00;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end

            ST_STREAM: begin
                if (accept) begin
                    ptr_d = ptr_q + 2'd1;
                end
                if (last_accept) begin
                    count_d = count_q + 8'd1;
                    ptr_d   = C00;
                    // A done landing exactly on the final accept is taken
                    // as the next tile rather than treated as an overrun.
                    if (mmu_done) begin
                        state_d = ST_CAPTURE;
                        idx_d   = C00;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (mmu_done) begin
                    ovf_set = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = C00;
                ptr_d   = C00;
            end
        endcase

        // Set has priority over a simultaneous clear.
        overflow_d = ovf_set || (overflow_q && !clr_overflow);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= C00;
            ptr_q      <= C00;
            overflow_q <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ELEMS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ELEMS; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all decoded from registered state, so reset zeroes them)
    // ------------------------------------------------------------------
    always_comb begin
        output_en  = 1'b0;
        output_sel = C00;
        m_valid    = 1'b0;
        m_data     = '0;
        m_last     = 1'b0;
        if (state_q == ST_CAPTURE) begin
            output_en  = 1'b1;
            output_sel = idx_q;
        end
        if (state_q == ST_STREAM) begin
            m_valid = 1'b1;
            m_data  = buf_q[ptr_q];
            m_last  = is_last_elem(ptr_q);
        end
    end

    assign overflow     = overflow_q;
    assign result_count = count_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_result_streamer.sv
module tb_result_streamer;
  import tpu_pkg::*;

  localparam int DATA_W = 8;
  localparam int W = DATA_W + 1;  // {last, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              mmu_done;
  logic [DATA_W-1:0] c_data;
  logic              output_en;
  logic [1:0]        output_sel;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              overflow;
  logic              clr_overflow;
  logic [7:0]        result_count;
  stream_state_e     dbg_state;

  // Controller model: C tile, read combinationally through output_en/sel.
  logic [DATA_W-1:0] c_mat [4];
  assign c_data = output_en ? c_mat[output_sel] : '0;

  result_streamer #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mmu_done     (mmu_done),
    .c_data       (c_data),
    .output_en    (output_en),
    .output_sel   (output_sel),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .result_count (result_count),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int frames_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on every accepted beat, checks hold-while-stalled.
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !m_valid) check("valid_dropped", 32'(m_valid), 32'd1);
      if (m_valid) begin
        if (prev_stall) begin
          check("hold_data", 32'(m_data), 32'(prev_data));
          check("hold_last", 32'(m_last), 32'(prev_last));
        end
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(m_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 32'(m_data), 32'(e[DATA_W-1:0]));
            check("beat_last", 32'(m_last), 32'(e[DATA_W]));
            if (e[DATA_W]) frames_done++;
          end
        end
        prev_stall = !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_frame(input logic [DATA_W-1:0] a, b, c, d);
    c_mat[0] = a; c_mat[1] = b; c_mat[2] = c; c_mat[3] = d;
    exp_q.push_back({1'b0, a});
    exp_q.push_back({1'b0, b});
    exp_q.push_back({1'b0, c});
    exp_q.push_back({1'b1, d});
  endtask

  // Raises done so that the next rising edge samples it; returns 1ns after.
  task automatic pulse_done;
    mmu_done = 1'b1;
    @(posedge clk); #1;
    mmu_done = 1'b0;
  endtask

  task automatic pulse_clr;
    clr_overflow = 1'b1;
    @(posedge clk); #1;
    clr_overflow = 1'b0;
  endtask

  task automatic wait_drained;
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    rst_n = 1'b0; mmu_done = 1'b0; m_ready = 1'b0; clr_overflow = 1'b0;
    for (int i = 0; i < 4; i++) c_mat[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_output_en", 32'(output_en), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_count", 32'(result_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: basic frame, sel sequence and 5-cycle latency
    m_ready = 1'b1;
    load_frame(8'd1, 8'd2, 8'd3, 8'd4);
    pulse_done;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("cap_en", 32'(output_en), 32'd1);
      check("cap_sel", 32'(output_sel), 32'(k));
      check("cap_valid", 32'(m_valid), 32'd0);
    end
    @(negedge clk);
    check("first_valid", 32'(m_valid), 32'd1);
    check("first_en_off", 32'(output_en), 32'd0);
    @(posedge clk); #1;
    wait_drained;
    check("count_t1", 32'(result_count), 32'd1);

    // T2: m_ready toggling 1010..., payload held while stalled
    load_frame(8'hFF, 8'h80, 8'h00, 8'h7F);
    pulse_done;
    for (int i = 0; i < 20; i++) begin
      m_ready = (i % 2 == 0);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    wait_drained;
    check("ovf_t2", 32'(overflow), 32'd0);
    check("count_t2", 32'(result_count), 32'd2);

    // T3: done during capture index 2 -> overflow, frame intact
    load_frame(8'h11, 8'h22, 8'h33, 8'h44);
    pulse_done;
    repeat (2) begin @(posedge clk); #1; end
    pulse_done;
    check("ovf_set_cap", 32'(overflow), 32'd1);
    wait_drained;
    check("ovf_sticky", 32'(overflow), 32'd1);
    pulse_clr;
    check("ovf_clr", 32'(overflow), 32'd0);

    // T3b: set wins over simultaneous clear (done while stalled in STREAM)
    m_ready = 1'b0;
    load_frame(8'h55, 8'h66, 8'h77, 8'h88);
    pulse_done;
    repeat (6) begin @(posedge clk); #1; end
    mmu_done = 1'b1; clr_overflow = 1'b1;
    @(posedge clk); #1;
    mmu_done = 1'b0; clr_overflow = 1'b0;
    check("ovf_set_prio", 32'(overflow), 32'd1);
    pulse_clr;
    check("ovf_clr2", 32'(overflow), 32'd0);
    m_ready = 1'b1;
    wait_drained;
    check("count_t3", 32'(result_count), 32'd4);

    // T4: done coincides with last-beat accept -> straight into CAPTURE
    load_frame(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    pulse_done;                                   // sampled at edge T
    repeat (5) begin @(posedge clk); #1; end      // now after edge T+5
    load_frame(8'hB1, 8'hB2, 8'hB3, 8'hB4);       // frame A already captured
    repeat (2) begin @(posedge clk); #1; end      // after edge T+7
    pulse_done;                                   // sampled at edge T+8
    check("ovf_back2back", 32'(overflow), 32'd0);
    @(negedge clk);
    check("b2b_en", 32'(output_en), 32'd1);
    check("b2b_sel", 32'(output_sel), 32'd0);
    @(posedge clk); #1;
    wait_drained;
    check("count_t4", 32'(result_count), 32'd6);

    // T5: reset mid-STREAM after beat 1
    m_ready = 1'b0;
    load_frame(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    pulse_done;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid) begin seen = 1'b1; break; end
    end
    check("t5_valid_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;                           // beat 1 accepted
    m_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(m_valid), 32'd0);
    check("rst_mid_data", 32'(m_data), 32'd0);
    check("rst_mid_last", 32'(m_last), 32'd0);
    check("rst_mid_en", 32'(output_en), 32'd0);
    check("rst_mid_sel", 32'(output_sel), 32'd0);
    check("rst_mid_count", 32'(result_count), 32'd0);
    exp_q.delete();
    frames_done = 0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid || output_en) seen = 1'b1;
    end
    check("post_rst_quiet", 32'(seen), 32'd0);
    @(posedge clk); #1;

    // T6: 256 frames -> result_count wraps to 0
    for (int f = 0; f < 256; f++) begin
      load_frame(8'(f), 8'(f + 1), 8'(f * 3), 8'(~f));
      pulse_done;
      wait_drained;
      if (f == 254) check("count_255", 32'(result_count), 32'd255);
    end
    check("count_wrap", 32'(result_count), 32'd0);
    check("frames_seen", 32'(frames_done), 32'd256);
    check("ovf_final", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/result_streamer.md
RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 Parameter DATA_W, default 8, element width; it SHALL match the controller out_data width.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 mmu_done  input  1  done pulse from controller, one cycle wide.
REQ-005 c_data  input  DATA_W  controller out_data, combinational from output_en/output_sel.
REQ-006 output_en  output  1  read enable to controller.
REQ-007 output_sel  output  2  C element index to controller: 0=C00, 1=C01, 2=C10, 3=C11.
REQ-008 m_valid  output  1  stream beat valid.
REQ-009 m_ready  input  1  downstream accept.
REQ-010 m_data  output  DATA_W  stream beat payload.
REQ-011 m_last  output  1  high on the C11 beat only.
REQ-012 overflow  output  1  sticky flag: result dropped.
REQ-013 clr_overflow  input  1  synchronous clear of overflow.
REQ-014 result_count  output  8  completed result frames, wraps 255->0.

Function
REQ-015 States SHALL be IDLE, CAPTURE and STREAM.
REQ-016 IDLE with mmu_done=1 SHALL go to CAPTURE next cycle, with capture index 0.
REQ-017 CAPTURE SHALL last exactly 4 cycles, with output_en=1 and output_sel=index 0,1,2,3.
REQ-018 In each CAPTURE cycle, c_data SHALL be registered into buffer[index] at the clock edge.
REQ-019 After index 3, CAPTURE SHALL go to STREAM with beat pointer 0.
REQ-020 output_en SHALL be 0 and output_sel SHALL be 0 outside CAPTURE.
REQ-021 Latency: done sampled at edge T gives first m_valid=1 in the cycle after edge T+4 (5 cycles).
REQ-022 STREAM SHALL hold m_valid=1 with m_data=buffer[ptr]; m_data/m_last SHALL stay stable until the beat is accepted (m_valid&m_ready).
REQ-023 Each accepted beat SHALL increment ptr; m_last SHALL equal (ptr==3).
REQ-024 Acceptance of the last beat SHALL increment result_count and return to IDLE.
REQ-025 If mmu_done coincides with last-beat acceptance, the block SHALL go directly to CAPTURE, with no overflow.
REQ-026 mmu_done in CAPTURE, or in STREAM other than REQ-025, SHALL set overflow and be ignored; the buffer SHALL stay intact.
REQ-027 clr_overflow SHALL clear overflow; a simultaneous set SHALL take priority.
REQ-028 m_valid SHALL be 0 in IDLE and CAPTURE; m_ready SHALL be ignored there.
REQ-029 The controller holds C stable for at least 5 cycles after done (reload takes at least 8 cycles), so capture needs no handshake.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, index/ptr 0, buffer 0, result_count 0 and overflow 0.
REQ-031 During reset, output_en, output_sel, m_valid, m_data and m_last SHALL all be 0.
REQ-032 Reset mid-CAPTURE or mid-STREAM SHALL abandon the frame; no beat SHALL appear after deassertion until a new mmu_done.

Structure
REQ-033 The state enum and the element-index constants (C00..C11=0..3, ELEMS=4) SHALL live in shared package tpu_pkg, which the controller also uses.
REQ-034 The block SHALL be a single module with no sub-modules; the 4xDATA_W buffer SHALL be flops.

Verification
REQ-035 C={1,2,3,4}, done pulse, m_ready=1 -> output_sel 0,1,2,3 over 4 cycles; beats 1,2,3,4 start 5 cycles after done; m_last on 4; result_count=1.
REQ-036 m_ready toggled 1010... with C={0xFF,0x80,0x00,0x7F} -> payload held stable while stalled; 4 beats in order; no overflow.
REQ-037 Second done during CAPTURE index 2 -> overflow=1; first frame streams unchanged; clr_overflow pulse -> overflow=0.
REQ-038 Second done in the same cycle as the last-beat accept -> no overflow; new CAPTURE starts next cycle; second frame streamed.
REQ-039 rst_n low mid-STREAM after beat 1 -> all outputs 0 immediately; after release, m_valid stays 0 until a new done.
REQ-040 256 frames streamed -> result_count wraps to 0.
